// File: rtl/gb_cpu_pkg.sv
// Shared definitions for the SM83-style CPU core: opcode constants,
// register and data-bus select encodings used by decode, and the
// instruction-fetch state encoding.
package gb_cpu_pkg;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_HALT      = 8'h76;
    localparam logic [7:0] OP_PREFIX_CB = 8'hCB;

    // Register field encoding as it appears in the opcode bits.
    typedef enum logic [2:0] {
        REG_B  = 3'd0,
        REG_C  = 3'd1,
        REG_D  = 3'd2,
        REG_E  = 3'd3,
        REG_H  = 3'd4,
        REG_L  = 3'd5,
        MEM_HL = 3'd6,
        REG_A  = 3'd7
    } reg_sel_t;

    // Source select for the internal data bus.
    typedef enum logic [1:0] {
        DBUS_SBUS  = 2'd0,
        DBUS_ALU   = 2'd1,
        DBUS_MEM   = 2'd2,
        DBUS_DEBUG = 2'd3
    } dbus_sel_t;

    // Instruction fetch FSM states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        FETCH_CB = 3'd2,
        HOLD     = 3'd3,
        HALTED   = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the program counter, fetches one opcode
// (two bytes for the CB prefix) per rising edge of decode's m1t1 strobe,
// accepts PC loads between fetches and parks in HALTED until wake.
module instr_fetch
    import gb_cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [7:0]  PREFIX_OP = OP_PREFIX_CB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m1t1,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    input  logic        halt_req,
    input  logic        wake,
    output logic        mem_rd_req,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rd_ack,
    output logic [7:0]  curr_op,
    output logic        op_cb,
    output logic        op_valid,
    output logic        fetch_busy,
    output logic [15:0] pc
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         m1t1_q;
    logic         trig;
    logic         fetching;

    // Edge-detect register; cleared by reset so the first m1t1 high triggers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) m1t1_q <= 1'b0;
        else      m1t1_q <= m1t1;
    end

    assign trig = m1t1 & ~m1t1_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic and outputs decoded from the registered state only.
    always_comb begin
        state_nxt  = state;
        fetching   = 1'b0;
        mem_rd_req = 1'b0;
        fetch_busy = 1'b0;
        op_valid   = 1'b0;
        mem_addr   = pc;
        case (state)
            IDLE: begin
                if (trig) state_nxt = FETCH;
            end
            HOLD: begin
                op_valid = 1'b1;
                // A halt takes priority over a new fetch request.
                if (halt_req)  state_nxt = HALTED;
                else if (trig) state_nxt = FETCH;
            end
            HALTED: begin
                if (wake) state_nxt = FETCH;
            end
            FETCH: begin
                fetching   = 1'b1;
                mem_rd_req = 1'b1;
                fetch_busy = 1'b1;
                if (mem_rd_ack)
                    state_nxt = (mem_rdata == PREFIX_OP) ? FETCH_CB : HOLD;
            end
            FETCH_CB: begin
                fetching   = 1'b1;
                mem_rd_req = 1'b1;
                fetch_busy = 1'b1;
                // Any byte here, including another CB, is the final opcode.
                if (mem_rd_ack) state_nxt = HOLD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // PC and opcode registers: advance on each acked byte, load between fetches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            curr_op <= OP_NOP;
            op_cb   <= 1'b0;
        end else if (fetching) begin
            if (mem_rd_ack) begin
                pc <= pc + 16'd1;
                if (state == FETCH_CB || mem_rdata != PREFIX_OP) begin
                    curr_op <= mem_rdata;
                    op_cb   <= (state == FETCH_CB);
                end
            end
        end else if (pc_load) begin
            pc <= pc_load_val;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written
// latency / wait / halt / reset sequences, and a randomized run checked
// against a byte-level model of opcode fetch.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        m1t1;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        halt_req;
    logic        wake;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_rd_ack;
    logic [7:0]  curr_op;
    logic        op_cb;
    logic        op_valid;
    logic        fetch_busy;
    logic [15:0] pc;

    instr_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .m1t1       (m1t1),
        .pc_load    (pc_load),
        .pc_load_val(pc_load_val),
        .halt_req   (halt_req),
        .wake       (wake),
        .mem_rd_req (mem_rd_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rd_ack (mem_rd_ack),
        .curr_op    (curr_op),
        .op_cb      (op_cb),
        .op_valid   (op_valid),
        .fetch_busy (fetch_busy),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    // Memory model and responder state.
    logic [7:0]  mem [65536];
    int          waits   = 0;
    int          wcnt    = 0;
    bit          resp_en = 1'b1;
    logic [15:0] req_log [$];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] start;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          nwait;
        logic [7:0]  op;
        logic        cb;
        logic [15:0] npc;
        int          nreq;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks after 'waits' request cycles, logs acked addresses.
    initial begin
        mem_rd_ack = 1'b0;
        mem_rdata  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                if (rst && mem_rd_req) begin
                    if (wcnt >= waits) begin
                        mem_rd_ack = 1'b1;
                        mem_rdata  = mem[mem_addr];
                        req_log.push_back(mem_addr);
                        wcnt = 0;
                    end else begin
                        mem_rd_ack = 1'b0;
                        wcnt++;
                    end
                end else begin
                    mem_rd_ack = 1'b0;
                    wcnt = 0;
                end
            end
        end
    end

    // Wait (bounded) for op_valid; returns number of busy cycles seen.
    task automatic wait_valid(output int busy);
        int n;
        busy = 0;
        n = 0;
        while (!op_valid && n < 60) begin
            if (fetch_busy) busy++;
            step();
            n++;
        end
        if (!op_valid) chk("op_valid_timeout", {31'd0, op_valid}, 32'd1);
    endtask

    // Trigger one fetch (optionally with a coincident PC load).
    task automatic fetch_op(input bit load, input logic [15:0] lval, output int busy);
        req_log.delete();
        m1t1 = 1'b1;
        pc_load = load;
        pc_load_val = lval;
        step();
        m1t1 = 1'b0;
        pc_load = 1'b0;
        wait_valid(busy);
    endtask

    initial begin
        int          busy;
        int          reqs;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] p;
        logic [15:0] held_pc;
        logic [7:0]  held_op;
        logic [7:0]  eop;
        logic        ecb;
        logic [15:0] enpc;
        logic [15:0] eaddr [$];
        bit          stable;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        vecs[0] = '{16'h0010, 8'hCB, 8'h37, 0, 8'h37, 1'b1, 16'h0012, 2};
        vecs[1] = '{16'hC000, 8'h41, 8'h99, 0, 8'h41, 1'b0, 16'hC001, 1};
        vecs[2] = '{16'h1234, 8'h76, 8'h00, 3, 8'h76, 1'b0, 16'h1235, 1};
        vecs[3] = '{16'hFFFF, 8'h00, 8'h12, 0, 8'h00, 1'b0, 16'h0000, 1};
        vecs[4] = '{16'hFFFF, 8'hCB, 8'hCB, 1, 8'hCB, 1'b1, 16'h0001, 2};
        vecs[5] = '{16'h2000, 8'hCB, 8'h7C, 2, 8'h7C, 1'b1, 16'h2002, 2};

        rst = 1'b0;
        m1t1 = 1'b0;
        pc_load = 1'b0;
        pc_load_val = 16'h0000;
        halt_req = 1'b0;
        wake = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_pc", pc, 16'h0000);
        chk("rst_curr_op", curr_op, 8'h00);
        chk("rst_op_cb", op_cb, 1'b0);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_mem_rd_req", mem_rd_req, 1'b0);
        chk("rst_fetch_busy", fetch_busy, 1'b0);

        // First fetch latency, zero waits
        mem[16'h0000] = 8'h41;
        waits = 0;
        rst = 1'b1;
        step();
        req_log.delete();
        m1t1 = 1'b1;
        step();
        m1t1 = 1'b0;
        chk("lat_req", mem_rd_req, 1'b1);
        chk("lat_addr", mem_addr, 16'h0000);
        chk("lat_busy", fetch_busy, 1'b1);
        chk("lat_valid_early", op_valid, 1'b0);
        step();
        chk("lat_valid", op_valid, 1'b1);
        chk("lat_op", curr_op, 8'h41);
        chk("lat_cb", op_cb, 1'b0);
        chk("lat_pc", pc, 16'h0001);
        chk("lat_busy_done", fetch_busy, 1'b0);

        // Wait states: request and address held until ack
        mem[16'h0001] = 8'h10;
        waits = 3;
        m1t1 = 1'b1;
        step();
        m1t1 = 1'b0;
        a0 = mem_addr;
        stable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (!(mem_rd_req && mem_addr == a0 && !op_valid)) stable = 1'b0;
            step();
        end
        chk("wait_stable", {31'd0, stable}, 32'd1);
        chk("wait_addr", a0, 16'h0001);
        chk("wait_valid", op_valid, 1'b1);
        chk("wait_op", curr_op, 8'h10);

        // Directed vector table, each with a coincident PC load
        for (int i = 0; i < 6; i++) begin
            a1 = vecs[i].start + 16'd1;
            mem[vecs[i].start] = vecs[i].b0;
            mem[a1] = vecs[i].b1;
            waits = vecs[i].nwait;
            fetch_op(1'b1, vecs[i].start, busy);
            chk($sformatf("vec%0d_op", i), curr_op, vecs[i].op);
            chk($sformatf("vec%0d_cb", i), op_cb, vecs[i].cb);
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].npc);
            chk($sformatf("vec%0d_nreq", i), req_log.size(), vecs[i].nreq);
            if (req_log.size() > 0) chk($sformatf("vec%0d_addr0", i), req_log[0], vecs[i].start);
            if (vecs[i].nwait == 0)
                chk($sformatf("vec%0d_busy", i), busy, vecs[i].nreq);
        end

        // HALT: halt_req beats a simultaneous trigger, fetch stays suspended
        waits = 0;
        held_pc = pc;
        held_op = curr_op;
        halt_req = 1'b1;
        m1t1 = 1'b1;
        step();
        halt_req = 1'b0;
        m1t1 = 1'b0;
        reqs = 0;
        for (int k = 0; k < 8; k++) begin
            m1t1 = k[0];
            if (mem_rd_req || op_valid) reqs++;
            step();
        end
        m1t1 = 1'b0;
        step();
        chk("halt_no_req", reqs, 0);
        chk("halt_pc", pc, held_pc);
        chk("halt_op", curr_op, held_op);
        mem[held_pc] = 8'h3C;
        wake = 1'b1;
        step();
        wake = 1'b0;
        chk("wake_req", mem_rd_req, 1'b1);
        chk("wake_addr", mem_addr, held_pc);
        wait_valid(busy);
        chk("wake_op", curr_op, 8'h3C);
        chk("wake_pc", pc, held_pc + 16'd1);

        // HALT then pc_load with wake in the same cycle
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        mem[16'h3000] = 8'h05;
        pc_load = 1'b1;
        pc_load_val = 16'h3000;
        wake = 1'b1;
        step();
        pc_load = 1'b0;
        wake = 1'b0;
        chk("wakeld_addr", mem_addr, 16'h3000);
        wait_valid(busy);
        chk("wakeld_op", curr_op, 8'h05);
        chk("wakeld_pc", pc, 16'h3001);

        // Reset mid-fetch with a late ack
        resp_en = 1'b0;
        mem_rd_ack = 1'b0;
        m1t1 = 1'b1;
        step();
        m1t1 = 1'b0;
        chk("rstmid_req_before", mem_rd_req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_req", mem_rd_req, 1'b0);
        chk("rstmid_busy", fetch_busy, 1'b0);
        chk("rstmid_pc", pc, 16'h0000);
        chk("rstmid_op", curr_op, 8'h00);
        chk("rstmid_valid", op_valid, 1'b0);
        mem_rd_ack = 1'b1;
        mem_rdata = 8'h55;
        step();
        rst = 1'b1;
        step();
        step();
        mem_rd_ack = 1'b0;
        resp_en = 1'b1;
        step();
        chk("late_ack_op", curr_op, 8'h00);
        chk("late_ack_pc", pc, 16'h0000);
        chk("late_ack_req", mem_rd_req, 1'b0);
        chk("late_ack_cb", op_cb, 1'b0);

        // Randomized fetches against the byte-level model
        p = 16'h0000;
        for (int it = 0; it < 40; it++) begin
            bit          ld;
            logic [15:0] lv;
            ld = ($urandom_range(0, 2) == 0);
            lv = 16'($urandom);
            if (ld) p = lv;
            a1 = p + 16'd1;
            mem[p] = ($urandom_range(0, 2) == 0) ? 8'hCB : 8'($urandom);
            mem[a1] = 8'($urandom);
            waits = $urandom_range(0, 3);
            eaddr.delete();
            eaddr.push_back(p);
            if (mem[p] == 8'hCB) begin
                eaddr.push_back(a1);
                eop = mem[a1];
                ecb = 1'b1;
                enpc = p + 16'd2;
            end else begin
                eop = mem[p];
                ecb = 1'b0;
                enpc = p + 16'd1;
            end
            fetch_op(ld, lv, busy);
            chk("rnd_op", curr_op, eop);
            chk("rnd_cb", op_cb, ecb);
            chk("rnd_pc", pc, enpc);
            chk("rnd_nreq", req_log.size(), eaddr.size());
            for (int j = 0; j < eaddr.size() && j < req_log.size(); j++)
                chk("rnd_addr", req_log[j], eaddr[j]);
            p = enpc;
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
